// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the M-stage memory request controller.
package wisc_mem_pkg;
    localparam int MEM_MAX_WAIT_DEF = 15;
    localparam int MEM_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } mem_state_e;
endpackage

// File: rtl/mem_wait_cnt.sv
// Saturating wait counter for the BUSY phase; at_limit_o flags the timeout point.
module mem_wait_cnt
    import wisc_mem_pkg::*;
#(
    parameter int LIMIT = MEM_MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic at_limit_o
);
    localparam logic [MEM_CNT_W-1:0] LIM = MEM_CNT_W'(LIMIT);

    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != LIM)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q == LIM);
endmodule

// File: rtl/mem_req_ctrl.sv
// M-stage memory request controller: one outstanding access, timeout, halt/dump.
// Optional alignment error on odd addresses when MEM_ALIGN_CHECK_EN is defined.
module mem_req_ctrl
    import wisc_mem_pkg::*;
#(
    parameter int MAX_WAIT = MEM_MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dataAddrM,
    input  logic [15:0] wrtDataM,
    input  logic        memWrtM,
    input  logic        readEnM,
    input  logic        createDumpM,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stallM,
    output logic        validM,
    output logic [15:0] readDataM,
    output logic        errM,
    output logic        haltM
);
    mem_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        wr_q, wr_d, err_q, err_d;
    logic        cnt_clr, cnt_en, at_limit;
    logic        one_req, misalign;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = dataAddrM[0];
`else
    assign misalign = 1'b0;
`endif

    assign one_req = readEnM ^ memWrtM;

    mem_wait_cnt #(.LIMIT(MAX_WAIT)) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .at_limit_o (at_limit)
    );

    // Counter also ticks on the IDLE->BUSY edge so it equals the number of
    // BUSY cycles spent, including the current one.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        stallM  = 1'b0;
        mem_en  = 1'b0;
        case (state_q)
            ST_IDLE: if (rst) begin
                if (one_req && !misalign) begin
                    stallM  = 1'b1;
                    addr_d  = dataAddrM;
                    wdata_d = wrtDataM;
                    wr_d    = memWrtM;
                    cnt_en  = 1'b1;
                    state_d = ST_BUSY;
                end else if (readEnM || memWrtM) begin
                    stallM  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (createDumpM) begin
                    state_d = ST_HALT;
                end
            end
            ST_BUSY: begin
                mem_en = 1'b1;
                stallM = 1'b1;
                cnt_en = 1'b1;
                if (mem_done) begin
                    if (!wr_q) rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (at_limit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign validM    = (state_q == ST_DONE);
    assign errM      = validM & err_q;
    assign readDataM = rdata_q;
    assign haltM     = (state_q == ST_HALT);
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: expectations queued at request, checked at validM.
module tb_mem_req_ctrl;
    localparam int MW = 15;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0, rst;
    logic [15:0] dataAddrM, wrtDataM, mem_addr, mem_wdata, mem_rdata, readDataM;
    logic        memWrtM, readEnM, createDumpM, mem_en, mem_wr, mem_done;
    logic        stallM, validM, errM, haltM;

    mem_req_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .dataAddrM(dataAddrM), .wrtDataM(wrtDataM),
        .memWrtM(memWrtM), .readEnM(readEnM), .createDumpM(createDumpM),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stallM(stallM), .validM(validM),
        .readDataM(readDataM), .errM(errM), .haltM(haltM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          vcyc;
        int          stalls;
        int          ens;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rdata;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // done_at = cycle (request cycle is 0, first BUSY cycle is 1) carrying mem_done; 0 = never
    task automatic txn(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input int done_at, input logic [15:0] rdata);
        exp_t e;
        int   busy, stalls, ens, vc;
        logic en_ok, g_err;
        logic [15:0] g_rdata;
        stalls = 0; ens = 0; vc = -1; en_ok = 1'b1; g_err = 1'bx; g_rdata = 'x;
        if ((rd && wr) || (ALIGN && addr[0])) begin
            e.err = 1'b1; busy = 0;
        end else if (done_at >= 1 && done_at <= MW) begin
            e.err = 1'b0; busy = done_at;
            if (rd) m_rdata = rdata;
        end else begin
            e.err = 1'b1; busy = MW;
        end
        e.rdata = m_rdata; e.stalls = busy + 1; e.ens = busy; e.vcyc = busy + 1;
        sb.push_back(e);
        readEnM = rd; memWrtM = wr; dataAddrM = addr; wrtDataM = wdata;
        for (int c = 0; c < 300; c++) begin
            mem_done  = (done_at != 0) && (c == done_at);
            mem_rdata = mem_done ? rdata : 16'hDEAD;
            @(negedge clk);
            if (stallM) stalls++;
            if (mem_en) begin
                ens++;
                if (mem_addr !== addr || mem_wdata !== wdata || mem_wr !== wr) en_ok = 1'b0;
            end
            if (validM) begin
                vc = c; g_err = errM; g_rdata = readDataM;
                break;
            end
            @(posedge clk); #1;
            readEnM = 1'b0; memWrtM = 1'b0;
        end
        mem_done = 1'b0;
        e = sb.pop_front();
        chk({tag, "_vcyc"},   vc,      e.vcyc);
        chk({tag, "_err"},    g_err,   e.err);
        chk({tag, "_rdata"},  g_rdata, e.rdata);
        chk({tag, "_stalls"}, stalls,  e.stalls);
        chk({tag, "_ens"},    ens,     e.ens);
        chk({tag, "_bus"},    en_ok,   1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst = 1'b0; readEnM = 1'b1; memWrtM = 1'b0; createDumpM = 1'b0; mem_done = 1'b0;
        dataAddrM = 16'hFFFF; wrtDataM = 16'hFFFF; mem_rdata = 16'h0; m_rdata = 16'h0;

        // Reset and the first cycle after it
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ctl",  {mem_en, mem_wr, stallM, validM, errM, haltM}, 6'b0);
        chk("rst_bus",  {mem_addr, mem_wdata}, 32'h0);
        chk("rst_rdat", readDataM, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1; readEnM = 1'b0;
        @(negedge clk);
        chk("post_rst_ctl", {mem_en, mem_wr, stallM, validM, errM, haltM}, 6'b0);
        chk("post_rst_bus", {mem_addr, mem_wdata}, 32'h0);
        @(posedge clk); #1;

        txn("rd_beef", 1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF);
        txn("wr_1234", 1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'hAAAA);

        // mem_done outside BUSY must not load readDataM
        mem_done = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk);
        chk("idle_done", {validM, readDataM}, {1'b0, m_rdata});
        @(posedge clk); #1;
        mem_done = 1'b0;
        @(negedge clk);
        chk("idle_done2", readDataM, m_rdata);
        @(posedge clk); #1;

        txn("tmo",     1'b1, 1'b0, 16'h0022, 16'h0000, 0,  16'h0);
        txn("last",    1'b1, 1'b0, 16'h0024, 16'h0000, MW, 16'h1515);
        txn("both",    1'b1, 1'b1, 16'h0030, 16'h5555, 2,  16'h3333);
        txn("odd",     1'b1, 1'b0, 16'h0041, 16'h0000, 2,  16'h5A5A);

        // Reset in the second BUSY cycle
        readEnM = 1'b1; dataAddrM = 16'h0080;
        @(negedge clk);
        chk("mr_stall0", stallM, 1'b1);
        @(posedge clk); #1;
        readEnM = 1'b0;
        @(negedge clk);
        chk("mr_busy1", mem_en, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; m_rdata = 16'h0;
        @(negedge clk);
        chk("mr_after", {mem_en, stallM, validM, errM, haltM}, 5'b0);
        chk("mr_rdata", readDataM, 16'h0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (validM || mem_en) seen++;
        end
        chk("mr_quiet", seen, 0);
        @(posedge clk); #1;

        txn("rd_post", 1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h4242);

        // Access wins over a simultaneous dump; dump is re-sampled after DONE
        createDumpM = 1'b1;
        txn("dump_rd", 1'b1, 1'b0, 16'h0102, 16'h0000, 2, 16'hCAFE);
        @(negedge clk);
        chk("dump_idle", {haltM, stallM}, 2'b00);
        @(posedge clk); #1;
        createDumpM = 1'b0;
        @(negedge clk);
        chk("halt_set", {haltM, stallM, mem_en}, 3'b100);
        readEnM = 1'b1; memWrtM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("halt_hold", {mem_en, stallM, haltM, validM}, 4'b0010);
        end
        readEnM = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
